// File: rtl/guess_controller.sv
// guess_controller: round control for the guessing game. Consumes debounced
// button pulses, draws a secret from a free-running LFSR, tracks the guess and
// remaining tries, and drives registered hint/win/lose indications.
module guess_controller #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_TRIES = 7,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             up,
    input  logic             down,
    input  logic             enter,
    output logic [WIDTH-1:0] guess,
    output logic [WIDTH-1:0] secret,
    output logic [3:0]       tries_left,
    output logic             hint_high,
    output logic             hint_low,
    output logic             win,
    output logic             lose
);

    localparam int unsigned TRIES_W = 4;
    localparam logic [TRIES_W-1:0] TRIES_INIT = TRIES_W'(MAX_TRIES);
    localparam logic [WIDTH-1:0]   GUESS_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   GUESS_MIN  = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        WIN  = 2'd2,
        LOSE = 2'd3
    } state_t;

    state_t             state_q, state_n;
    logic [7:0]         lfsr_q, lfsr_n;
    logic [WIDTH-1:0]   guess_n, secret_n;
    logic [TRIES_W-1:0] tries_n;
    logic               hint_high_n, hint_low_n, win_n, lose_n;
    logic               lfsr_fb;

    // State and output registers; synchronous reset overrides every input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lfsr_q     <= LFSR_SEED;
            guess      <= '0;
            secret     <= '0;
            tries_left <= '0;
            hint_high  <= 1'b0;
            hint_low   <= 1'b0;
            win        <= 1'b0;
            lose       <= 1'b0;
        end else begin
            state_q    <= state_n;
            lfsr_q     <= lfsr_n;
            guess      <= guess_n;
            secret     <= secret_n;
            tries_left <= tries_n;
            hint_high  <= hint_high_n;
            hint_low   <= hint_low_n;
            win        <= win_n;
            lose       <= lose_n;
        end
    end

    // Next-state and next-output logic; priority start > enter > up/down.
    always_comb begin
        state_n     = state_q;
        guess_n     = guess;
        secret_n    = secret;
        tries_n     = tries_left;
        hint_high_n = hint_high;
        hint_low_n  = hint_low;
        win_n       = win;
        lose_n      = lose;

        lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
        lfsr_n  = {lfsr_q[6:0], lfsr_fb};

        if (start) begin
            secret_n    = lfsr_q[WIDTH-1:0];
            guess_n     = '0;
            tries_n     = TRIES_INIT;
            hint_high_n = 1'b0;
            hint_low_n  = 1'b0;
            win_n       = 1'b0;
            lose_n      = 1'b0;
            state_n     = PLAY;
        end else if (state_q == PLAY) begin
            if (enter) begin
                if (guess == secret) begin
                    win_n       = 1'b1;
                    hint_high_n = 1'b0;
                    hint_low_n  = 1'b0;
                    state_n     = WIN;
                end else begin
                    hint_high_n = (guess > secret);
                    hint_low_n  = (guess < secret);
                    if (tries_left != '0) begin
                        tries_n = tries_left - TRIES_W'(1);
                    end
                    if (tries_left <= TRIES_W'(1)) begin
                        lose_n  = 1'b1;
                        state_n = LOSE;
                    end
                end
            end else if (up && !down) begin
                if (guess != GUESS_MAX) begin
                    guess_n = guess + WIDTH'(1);
                end
            end else if (down && !up) begin
                if (guess != GUESS_MIN) begin
                    guess_n = guess - WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_guess_controller.sv
// tb_guess_controller: directed test-plan steps followed by randomized pulses,
// every cycle compared against a behavioural model of the game rules.
module tb_guess_controller;

    localparam int unsigned W     = 4;
    localparam int unsigned TRIES = 7;
    localparam logic [7:0]  SEED  = 8'hA5;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0, up = 1'b0, down = 1'b0, enter = 1'b0;
    logic [W-1:0] guess, secret;
    logic [3:0]   tries_left;
    logic         hint_high, hint_low, win, lose;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model: game rules only, no state encoding.
    int   m_guess, m_secret, m_tries;
    bit   m_hh, m_hl, m_win, m_lose, m_playing;
    logic [7:0] m_lfsr;

    guess_controller #(.WIDTH(W), .MAX_TRIES(TRIES), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start), .up(up), .down(down), .enter(enter),
        .guess(guess), .secret(secret), .tries_left(tries_left),
        .hint_high(hint_high), .hint_low(hint_low), .win(win), .lose(lose)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit u, input bit d, input bit e);
        int gmax;
        gmax = (1 << W) - 1;
        if (r) begin
            m_guess = 0; m_secret = 0; m_tries = 0;
            m_hh = 0; m_hl = 0; m_win = 0; m_lose = 0; m_playing = 0;
            m_lfsr = SEED;
            return;
        end
        if (s) begin
            m_secret  = int'(m_lfsr) % (1 << W);
            m_guess   = 0;
            m_tries   = TRIES;
            m_hh = 0; m_hl = 0; m_win = 0; m_lose = 0;
            m_playing = 1;
        end else if (m_playing) begin
            if (e) begin
                if (m_guess == m_secret) begin
                    m_win = 1; m_hh = 0; m_hl = 0; m_playing = 0;
                end else begin
                    m_hh = (m_guess > m_secret);
                    m_hl = (m_guess < m_secret);
                    if (m_tries == 1) begin
                        m_lose = 1; m_playing = 0;
                    end
                    if (m_tries > 0) m_tries = m_tries - 1;
                end
            end else if (u && !d) begin
                m_guess = (m_guess < gmax) ? m_guess + 1 : gmax;
            end else if (d && !u) begin
                m_guess = (m_guess > 0) ? m_guess - 1 : 0;
            end
        end
        m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    endtask

    task automatic check_model();
        chk("guess",      32'(guess),      32'(m_guess));
        chk("secret",     32'(secret),     32'(m_secret));
        chk("tries_left", 32'(tries_left), 32'(m_tries));
        chk("hint_high",  32'(hint_high),  32'(m_hh));
        chk("hint_low",   32'(hint_low),   32'(m_hl));
        chk("win",        32'(win),        32'(m_win));
        chk("lose",       32'(lose),       32'(m_lose));
        chk("hints_excl", 32'(hint_high & hint_low), 32'(0));
        chk("wl_excl",    32'(win & lose), 32'(0));
    endtask

    // One clock cycle: drive on negedge, model on posedge, check just after.
    task automatic cycle(input bit r, input bit s, input bit u, input bit d, input bit e);
        @(negedge clk);
        rst = r; start = s; up = u; down = d; enter = e;
        @(posedge clk);
        model_step(r, s, u, d, e);
        #1;
        check_model();
        rst = 0; start = 0; up = 0; down = 0; enter = 0;
    endtask

    initial begin
        int tr;
        // Reset for 2 cycles.
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        chk("rst_guess", 32'(guess), 0);
        chk("rst_tries", 32'(tries_left), 0);

        // Start on first cycle after reset: secret from seed low bits.
        cycle(0, 1, 0, 0, 0);
        chk("start_secret", 32'(secret), 5);
        chk("start_tries",  32'(tries_left), 7);

        // Saturation.
        cycle(0, 0, 0, 1, 0);
        chk("down_sat0", 32'(guess), 0);
        for (int i = 0; i < 20; i++) cycle(0, 0, 1, 0, 0);
        chk("up_sat15", 32'(guess), 15);
        cycle(0, 0, 1, 1, 0);
        chk("updown_hold", 32'(guess), 15);

        // Hints: guess 3 then 9 against secret 5.
        for (int i = 0; i < 12; i++) cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1);
        chk("low_hl",    32'(hint_low), 1);
        chk("low_tries", 32'(tries_left), 6);
        for (int i = 0; i < 6; i++) cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1);
        chk("high_hh",    32'(hint_high), 1);
        chk("high_tries", 32'(tries_left), 5);

        // Win, then further inputs ignored.
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1);
        chk("win",       32'(win), 1);
        chk("win_tries", 32'(tries_left), 5);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1);
        chk("win_hold_guess", 32'(guess), 5);
        chk("win_hold_win",   32'(win), 1);

        // Lose: seven wrong guesses.
        cycle(0, 1, 0, 0, 0);
        if (secret == 0) cycle(0, 0, 1, 0, 0);
        for (int i = 0; i < 7; i++) cycle(0, 0, 0, 0, 1);
        chk("lose",       32'(lose), 1);
        chk("lose_tries", 32'(tries_left), 0);
        chk("lose_hint",  32'(hint_high | hint_low), 1);
        cycle(0, 1, 0, 0, 0);
        chk("restart_lose",  32'(lose), 0);
        chk("restart_tries", 32'(tries_left), 7);

        // Start wins over enter; reset wins over everything.
        cycle(0, 0, 1, 0, 0);
        cycle(0, 1, 0, 0, 1);
        chk("start_enter_tries", 32'(tries_left), 7);
        chk("start_enter_guess", 32'(guess), 0);
        cycle(0, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 1);
        chk("rst_mid_guess", 32'(guess), 0);
        chk("rst_mid_tries", 32'(tries_left), 0);

        // Randomized pulses.
        for (int i = 0; i < 3000; i++) begin
            tr = (i < 3) ? 0 : 1;
            cycle(($urandom_range(0, 199) == 0) && tr == 1,
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/guess_controller.md
# guess_controller

Game-control stage that sits directly downstream of the button debouncers in the guessing game. It consumes their single-cycle `clean` pulses (start, up, down, enter) and draws a pseudo-random secret from a free-running LFSR. It tracks the player's current guess and remaining tries, and drives the higher/lower/win/lose indications read by the display and LED logic.

## Interface
- `WIDTH`, default 4: guess and secret width in bits; legal range 1..8.
- `MAX_TRIES`, default 7: tries granted per round; legal range 1..15.
- `LFSR_SEED`, default 8'hA5: LFSR reset value; must be nonzero.

Ports:
- `clk`, input, 1: system clock; all logic is on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: debounced single-cycle pulse; begins a new round.
- `up`, input, 1: debounced single-cycle pulse; increments the guess.
- `down`, input, 1: debounced single-cycle pulse; decrements the guess.
- `enter`, input, 1: debounced single-cycle pulse; submits the guess.
- `guess`, output, WIDTH: current guess.
- `secret`, output, WIDTH: current round's secret, for debug and bench.
- `tries_left`, output, 4: remaining tries.
- `hint_high`, output, 1: last submitted guess was greater than the secret.
- `hint_low`, output, 1: last submitted guess was less than the secret.
- `win`, output, 1: round won.
- `lose`, output, 1: round lost.

## Operation
- **Clocking and reset.** One clock, `clk`. Reset `rst` is synchronous and active-high.
- **Reset values.** State = IDLE. `guess`, `secret`, `tries_left`, `hint_high`, `hint_low`, `win` and `lose` all = 0. `lfsr` = `LFSR_SEED`.
- **LFSR.**
  - 8-bit Fibonacci: `fb = lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]`, next = `{lfsr[6:0], fb}`, period 255.
  - Advances every cycle in every state except during `rst`.
- **States.** IDLE, PLAY, WIN, LOSE.
- **Input priority within a cycle:** `start` > `enter` > `up`/`down`.
- **Start (any state):**
  - `secret` <= `lfsr[WIDTH-1:0]`, the pre-advance value in that cycle.
  - `guess` <= 0; `tries_left` <= `MAX_TRIES`.
  - `hint_high`, `hint_low`, `win`, `lose` <= 0.
  - Next state = PLAY. A `start` in PLAY abandons the current round.
- **PLAY, `up` without `down`:** `guess` + 1, saturating at 2^WIDTH-1.
- **PLAY, `down` without `up`:** `guess` - 1, saturating at 0.
- **PLAY, `up` and `down` together:** no change.
- **Hint persistence:** `up`/`down` do not alter the hints.
- **PLAY, `enter`:**
  - `guess == secret`:
    - `win` <= 1; hints <= 0; next state = WIN.
    - `tries_left` is unchanged.
  - Otherwise:
    - `hint_high` <= (`guess > secret`); `hint_low` <= (`guess < secret`).
    - `tries_left` <= `tries_left` - 1.
    - If `tries_left` was 1: `lose` <= 1, next state = LOSE. Hints are retained.
  - `up`/`down` arriving in the same cycle as `enter` are dropped.
- **IDLE, WIN, LOSE:**
  - `up`, `down` and `enter` are ignored.
  - All outputs hold until `start` or `rst`.
- **Flag exclusivity:**
  - `hint_high` and `hint_low` are never both 1.
  - `win` and `lose` are never both 1.
  - `win` = 1 implies both hints = 0.
- **Arithmetic:** unsigned compares at WIDTH bits. `tries_left` never wraps below 0.

## Timing
- Every output is a registered value, updated on the rising edge that samples the input pulse. Latency is 1 cycle from the pulse cycle to the visible output.
- Inputs must be single-cycle pulses; each high cycle counts as one event. Level inputs are out of contract.
- Back-to-back pulses on consecutive cycles are each honoured. For example, `up` on 3 consecutive cycles gives `guess` +3.
- `rst` overrides every input in its cycle. Asserting `rst` mid-round returns all outputs to their reset values on the next edge, with no partial update.
- The secret is captured in the same edge that enters PLAY, so `secret` is valid one cycle after `start`.

## Test plan
- **Reset and start:**
  - Assert `rst` for 2 cycles: all outputs = 0.
  - With `LFSR_SEED`=8'hA5, pulse `start` on the 1st cycle after reset: `secret` = 4'h5, `tries_left` = 7, `guess` = 0, state PLAY.
- **Saturation:**
  - With `guess` = 0, pulse `down`: `guess` stays 0.
  - Pulse `up` 20 times at WIDTH=4: `guess` = 15.
  - Then pulse `up` and `down` in the same cycle: `guess` stays 15.
- **Hints:**
  - Secret = 5, `guess` = 3, pulse `enter`: `hint_low` = 1, `hint_high` = 0, `tries_left` = 6.
  - Then `guess` = 9, pulse `enter`: `hint_high` = 1, `hint_low` = 0, `tries_left` = 5.
- **Win:**
  - Secret = 5, `guess` = 5, pulse `enter`: `win` = 1, hints = 0, `tries_left` unchanged.
  - Subsequent `up` and `enter` change nothing.
- **Lose:**
  - Submit 7 wrong guesses: on the 7th, `tries_left` = 0 and `lose` = 1, with the hint from the 7th guess retained.
  - Then pulse `start`: `lose` = 0, `tries_left` = 7, new `secret` captured.
- **Priority and reset:**
  - In PLAY, pulse `start` and `enter` in the same cycle: restart only, no try consumed.
  - Assert `rst` mid-round with `enter` high: all outputs = 0, state IDLE.
